// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder/subtractor.
package serial_adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Bit-counter width for a given operand width; never narrower than one bit.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Combinational one-bit full adder, the only arithmetic in the serial datapath.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic c
);

  assign s = a ^ b ^ ci;
  assign c = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract: one bit per cycle, LSB first, through a single full adder.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, done_q, done_d;
  logic             fa_s, fa_c;

  fa_cell u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .c  (fa_c)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    if (state_q == IDLE && start) begin
      // Subtraction is a + ~b + 1, so the inverted operand and forced carry do it.
      a_d     = a;
      b_d     = sub ? ~b : b;
      carry_d = sub ? 1'b1 : cin;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      res_d   = {fa_s, res_q[WIDTH-1:1]};
      carry_d = fa_c;
      cnt_d   = cnt_q + CW'(1);
      if (cnt_q == LAST) begin
        // On the MSB cycle carry_q is the carry into the MSB.
        sum_d  = {fa_s, res_q[WIDTH-1:1]};
        cout_d = fa_c;
        ovf_d  = fa_c ^ carry_q;
        done_d = 1'b1;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8 with hand-computed results.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sub = 1'b0;
  logic       cin = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       busy, done, cout, ovf;
  logic [7:0] sum;

  int n_vec = 0;
  int n_err = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .cin   (cin),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one start pulse; returns just after the accepting edge.
  task automatic start_op(input logic s, input logic c, input logic [7:0] x, input logic [7:0] y);
    sub = s; cin = c; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts edges until done is seen; -1 if it never arrives.
  task automatic wait_done(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_vec++;
    if ({busy, done, sum, cout, ovf} !== 12'h000) begin
      n_err++;
      $display("FAIL reset: busy=%b done=%b sum=%h cout=%b ovf=%b, required all zero", busy, done, sum, cout, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    $display("reset: busy=%b done=%b sum=%h", busy, done, sum);
  endtask

  task automatic test_add(input logic c, input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] exp_sum, input logic exp_cout, input logic exp_ovf);
    int cyc;
    start_op(1'b0, c, x, y);
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL add_busy: busy=%b required 1", busy);
    end
    wait_done(cyc);
    n_vec++;
    if (cyc !== 8) begin
      n_err++;
      $display("FAIL add_latency: cycles=%0d required 8", cyc);
    end
    n_vec++;
    if ({sum, cout, ovf} !== {exp_sum, exp_cout, exp_ovf}) begin
      n_err++;
      $display("FAIL add_result %h+%h+%b: sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
               x, y, c, sum, cout, ovf, exp_sum, exp_cout, exp_ovf);
    end
    tick();
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL add_pulse: done=%b busy=%b required 0 0", done, busy);
    end
    $display("add %h+%h+%b -> sum=%h cout=%b ovf=%b in %0d cycles", x, y, c, sum, cout, ovf, cyc);
  endtask

  task automatic test_sub(input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] exp_sum, input logic exp_cout, input logic exp_ovf);
    int cyc;
    start_op(1'b1, 1'b0, x, y);
    wait_done(cyc);
    n_vec++;
    if (cyc !== 8 || {sum, cout, ovf} !== {exp_sum, exp_cout, exp_ovf}) begin
      n_err++;
      $display("FAIL sub_result %h-%h: cycles=%0d sum=%h cout=%b ovf=%b required 8 sum=%h cout=%b ovf=%b",
               x, y, cyc, sum, cout, ovf, exp_sum, exp_cout, exp_ovf);
    end
    tick();
    $display("sub %h-%h -> sum=%h cout=%b ovf=%b", x, y, sum, cout, ovf);
  endtask

  task automatic test_ignore_start();
    int n_done = 0;
    int done_at = -1;
    logic [7:0] prev_sum;
    prev_sum = sum;
    start_op(1'b0, 1'b0, 8'h10, 8'h20);
    for (int i = 1; i <= 16; i++) begin
      if (i == 3) begin
        sub = 1'b1; a = 8'h55; b = 8'h66; start = 1'b1;
      end
      if (i == 4) start = 1'b0;
      tick();
      if (busy && sum !== prev_sum) begin
        n_vec++;
        n_err++;
        $display("FAIL ignore_hold: sum=%h changed while busy, required %h", sum, prev_sum);
      end
      if (done) begin
        n_done++;
        done_at = i;
      end
    end
    n_vec++;
    if (n_done !== 1 || done_at !== 8) begin
      n_err++;
      $display("FAIL ignore_done: pulses=%0d at=%0d required 1 at 8", n_done, done_at);
    end
    n_vec++;
    if ({sum, cout, ovf} !== {8'h30, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL ignore_result: sum=%h cout=%b ovf=%b required 30 0 0", sum, cout, ovf);
    end
    $display("ignore-start: pulses=%0d sum=%h", n_done, sum);
  endtask

  task automatic test_back_to_back();
    int d1 = -1;
    int d2 = -1;
    sub = 1'b0; cin = 1'b0; a = 8'h01; b = 8'h02; start = 1'b1;
    tick();
    sub = 1'b1; a = 8'h0A; b = 8'h03;
    for (int i = 1; i <= 24 && d2 < 0; i++) begin
      tick();
      if (d1 >= 0 && i == d1 + 1) begin
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_accept: busy=%b required 1", busy);
        end
      end
      if (done) begin
        if (d1 < 0) begin
          d1 = i;
          n_vec++;
          if ({sum, cout, ovf} !== {8'h03, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL b2b_first: sum=%h cout=%b ovf=%b required 03 0 0", sum, cout, ovf);
          end
        end else begin
          d2 = i;
        end
      end
    end
    start = 1'b0;
    n_vec++;
    if (d1 !== 8 || d2 - d1 !== 9) begin
      n_err++;
      $display("FAIL b2b_spacing: first=%0d second=%0d required 8 and 17", d1, d2);
    end
    n_vec++;
    if ({sum, cout, ovf} !== {8'h07, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL b2b_second: sum=%h cout=%b ovf=%b required 07 1 0", sum, cout, ovf);
    end
    tick();
    $display("back-to-back: done at %0d and %0d, sum=%h", d1, d2, sum);
  endtask

  task automatic test_reset_mid_run();
    int n_done = 0;
    int cyc;
    start_op(1'b0, 1'b0, 8'h33, 8'h44);
    tick(); tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (busy !== 1'b0 || sum !== 8'h00 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: busy=%b sum=%h done=%b required 0 00 0", busy, sum, done);
    end
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) n_done++;
    end
    n_vec++;
    if (n_done !== 0) begin
      n_err++;
      $display("FAIL reset_nodone: pulses=%0d required 0", n_done);
    end
    start_op(1'b0, 1'b1, 8'h12, 8'h34);
    wait_done(cyc);
    n_vec++;
    if (cyc !== 8 || {sum, cout, ovf} !== {8'h47, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_recover: cycles=%0d sum=%h cout=%b ovf=%b required 8 47 0 0", cyc, sum, cout, ovf);
    end
    tick();
    $display("reset mid-run: stray pulses=%0d, recovery sum=%h", n_done, sum);
  endtask

  initial begin
    test_reset();
    test_add(1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    test_add(1'b1, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0);
    test_sub(8'h05, 8'h07, 8'hFE, 1'b0, 1'b0);
    test_sub(8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
